bist_sequencer: RTL and testbench
=================================

Name: bist_sequencer

Overview:
- Synthesizable test-case sequencer for on-FPGA self-test runs of the VGA/ASCII datapath.
- Steps through numbered test cases, holds the DUT in reset before each case, and counts cycles per case with a timeout.
- Collects per-case pass/fail and reports an overall verdict.
- Hardware counterpart of the simulation harness: one case or all cases, per-case reset, cycle count, timeout abort.

Parameters:
- NUM_CASES, 8, number of test cases; case IDs are 1..NUM_CASES.
- RESET_CYCLES, 3, cycles dut_reset is held high before each case; must be >=1.
- TIMEOUT, 10000, maximum RUN cycles per case before abort; must be >=2.
- CW, 32, cycle counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE and DONE only.
- case_sel  in  $clog2(NUM_CASES+1)  0 = run all cases in order; k = run only case k.
- case_done  in  1  DUT/checker signals the current case finished.
- case_fail  in  1  check failure pulse for the current case.
- dut_reset  out  1  active-high reset to the DUT.
- case_id  out  $clog2(NUM_CASES+1)  case currently running; 0 when none.
- case_active  out  1  high in RUN.
- cycles  out  CW  RUN-cycle count of the current case.
- busy  out  1  high in RST, RUN and REC.
- done  out  1  high in DONE.
- pass  out  1  valid when done.
- timeout  out  1  sticky: a case timed out.
- fail_mask  out  NUM_CASES  bit i-1 set if case i failed.

Behaviour:
- States: IDLE, RST, RUN, REC, DONE.
- Reset (reset==0 at a posedge): state IDLE, dut_reset=1, case_id=0, cycles=0, fail_mask=0, timeout=0, pass=0, busy/done/case_active=0. Reset mid-run aborts immediately and behaves identically.
- IDLE: dut_reset=1.
  - start=1 latches case_sel.
  - Valid selection: case_id = sel==0 ? 1 : sel; next state RST.
  - sel > NUM_CASES: next state DONE with fail_mask=0, pass=0.
- RST: dut_reset=1 for exactly RESET_CYCLES cycles, then RUN. An internal sticky fail flag is cleared on entry.
- RUN: dut_reset=0, case_active=1.
  - cycles=0 on the first RUN cycle and increments by 1 each following cycle.
  - case_fail=1 in any RUN cycle sets the sticky flag.
  - case_done=1 moves to REC; a case_fail in that same cycle still counts.
  - case_done=0 while cycles==TIMEOUT-1 sets timeout=1 and fail_mask[case_id-1]=1, then goes to DONE. Remaining cases are skipped.
  - case_done wins over timeout in the same cycle.
  - case_done/case_fail are ignored outside RUN.
- REC (1 cycle): dut_reset=1; fail_mask[case_id-1] |= flag.
  - Run-all mode with case_id<NUM_CASES: case_id+1, next state RST.
  - Otherwise: next state DONE.
- DONE: done=1, dut_reset=1; case_id and cycles hold their last values.
  - pass = (fail_mask==0) & !timeout & valid selection.
  - start=1 clears fail_mask, timeout and pass, then follows the IDLE start rules.
- Latency: start to first dut_reset-low cycle = 1+RESET_CYCLES cycles. Inter-case gap = 1 (REC) + RESET_CYCLES cycles.
- start while busy is ignored.
- cycles never wraps, because timeout fires first.

Test Plan:
Bench parameters: NUM_CASES=4, RESET_CYCLES=3, TIMEOUT=20.
- Run all, no failures: start with sel=0; pulse case_done 5 RUN cycles after each RUN entry -> case_id steps 1,2,3,4; dut_reset high 3 cycles before each case; done=1, pass=1, fail_mask=4'b0000.
- Single case with failure: sel=3; case_fail at RUN cycle 2; case_done at RUN cycle 4 -> only case 3 runs; fail_mask=4'b0100, pass=0.
- Timeout: sel=0; case 2 never asserts case_done -> at cycles=19, timeout=1 and fail_mask=4'b0010; DONE next cycle; cases 3-4 never run (case_id stays 2).
- Simultaneous events: case_done and case_fail together in case 1, then case_done at cycles=19 in case 2 -> case 1 fails, case 2 passes (no timeout); fail_mask=4'b0001.
- Boundary and control: sel=5 -> DONE next cycle with pass=0; start during RUN -> ignored; reset low mid-RUN -> next cycle IDLE with all outputs at reset values and dut_reset=1.
- Restart from DONE: after the failing run above, start with sel=1 -> fail_mask cleared; run passes with pass=1.

Source files
------------

// File: rtl/bist_sequencer_if.sv
// -----------------------------------------------------------------------------
// bist_sequencer_if
// Bundle of the BIST sequencer's control/status signals.
//   master : test controller side (drives start/case_sel, reports case_done/case_fail)
//   slave  : sequencer side (drives dut_reset and all status outputs)
// Signals:
//   start       begin a run (sampled only when the sequencer is idle or done)
//   case_sel    0 = run all cases, k = run only case k
//   case_done   current case finished
//   case_fail   check failure pulse for the current case
//   dut_reset   active-high reset to the device under test
//   case_id     case currently running, 0 when none
//   case_active high while a case is running
//   cycles      run-cycle count of the current case
//   busy/done   sequencer activity / run complete
//   pass        overall verdict, valid with done
//   timeout     sticky, a case ran out of cycles
//   fail_mask   bit i-1 set when case i failed
// -----------------------------------------------------------------------------
interface bist_sequencer_if #(
   parameter int NUM_CASES = 8,
   parameter int CW        = 32
);
   localparam int IW = $clog2(NUM_CASES + 1);

   logic                 start;
   logic [IW-1:0]        case_sel;
   logic                 case_done;
   logic                 case_fail;
   logic                 dut_reset;
   logic [IW-1:0]        case_id;
   logic                 case_active;
   logic [CW-1:0]        cycles;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic                 timeout;
   logic [NUM_CASES-1:0] fail_mask;

   modport master (
      output start, case_sel, case_done, case_fail,
      input  dut_reset, case_id, case_active, cycles, busy, done, pass, timeout, fail_mask
   );

   modport slave (
      input  start, case_sel, case_done, case_fail,
      output dut_reset, case_id, case_active, cycles, busy, done, pass, timeout, fail_mask
   );
endinterface

// File: rtl/bist_sequencer.sv
// -----------------------------------------------------------------------------
// bist_sequencer
// Hardware test-case sequencer for on-FPGA self-test of the VGA/ASCII datapath.
// Runs one selected case or all cases in order; before each case the DUT is
// held in reset, then run cycles are counted until the case reports done or
// the timeout expires (which aborts the whole run).
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset (aborts any run)
//   bus    bist_sequencer_if.slave: start/case_sel/case_done/case_fail in,
//          dut_reset/case_id/case_active/cycles/busy/done/pass/timeout/
//          fail_mask out (all outputs registered)
// -----------------------------------------------------------------------------
module bist_sequencer #(
   parameter int NUM_CASES    = 8,
   parameter int RESET_CYCLES = 3,
   parameter int TIMEOUT      = 10000,
   parameter int CW           = 32
) (
   input  logic             clk,
   input  logic             reset,
   bist_sequencer_if.slave  bus
);
   localparam int IW = $clog2(NUM_CASES + 1);
   localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   localparam logic [IW-1:0] LAST_ID   = IW'(NUM_CASES);
   localparam logic [CW-1:0] CYC_LIMIT = CW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RST  = 3'd1,
      S_RUN  = 3'd2,
      S_REC  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // One-hot fail_mask bit for a case ID (ID 0 maps to no bit).
   function automatic logic [NUM_CASES-1:0] case_bit(input logic [IW-1:0] id);
      logic [NUM_CASES-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_CASES; i++) begin
         m[i] = (id == IW'(i + 1));
      end
      return m;
   endfunction

   state_t               state_r;
   logic                 dut_reset_r;
   logic [IW-1:0]        case_id_r;
   logic                 case_active_r;
   logic [CW-1:0]        cycles_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 pass_r;
   logic                 timeout_r;
   logic [NUM_CASES-1:0] fail_mask_r;
   logic                 flag_r;       // sticky failure of the current case
   logic [RW-1:0]        rst_cnt_r;
   logic                 run_all_r;
   logic                 sel_valid_r;

   logic [NUM_CASES-1:0] case_bit_s;
   logic [NUM_CASES-1:0] rec_mask_s;
   logic                 sel_bad_s;
   logic [IW-1:0]        first_id_s;

   // Selection decode and the fail mask as it will look after REC folds in the flag.
   always_comb begin
      case_bit_s = case_bit(case_id_r);
      rec_mask_s = fail_mask_r | (flag_r ? case_bit_s : {NUM_CASES{1'b0}});
      sel_bad_s  = (bus.case_sel > LAST_ID);
      first_id_s = (bus.case_sel == {IW{1'b0}}) ? IW'(1) : bus.case_sel;
   end

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r       <= S_IDLE;
         dut_reset_r   <= 1'b1;
         case_id_r     <= '0;
         case_active_r <= 1'b0;
         cycles_r      <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         pass_r        <= 1'b0;
         timeout_r     <= 1'b0;
         fail_mask_r   <= '0;
         flag_r        <= 1'b0;
         rst_cnt_r     <= '0;
         run_all_r     <= 1'b0;
         sel_valid_r   <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               dut_reset_r   <= 1'b1;
               case_active_r <= 1'b0;
               if (bus.start) begin
                  // A new run always starts from a clean verdict.
                  fail_mask_r <= '0;
                  timeout_r   <= 1'b0;
                  pass_r      <= 1'b0;
                  run_all_r   <= (bus.case_sel == {IW{1'b0}});
                  if (sel_bad_s) begin
                     state_r     <= S_DONE;
                     sel_valid_r <= 1'b0;
                     case_id_r   <= '0;
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                  end else begin
                     state_r     <= S_RST;
                     sel_valid_r <= 1'b1;
                     case_id_r   <= first_id_s;
                     rst_cnt_r   <= '0;
                     flag_r      <= 1'b0;
                     busy_r      <= 1'b1;
                     done_r      <= 1'b0;
                  end
               end else begin
                  state_r <= state_r;
               end
            end

            S_RST: begin
               if (rst_cnt_r == RST_LAST) begin
                  state_r       <= S_RUN;
                  dut_reset_r   <= 1'b0;
                  case_active_r <= 1'b1;
                  cycles_r      <= '0;
               end else begin
                  rst_cnt_r <= rst_cnt_r + 1'b1;
               end
            end

            S_RUN: begin
               flag_r <= flag_r | bus.case_fail;
               // case_done is checked first so it wins over an expiring timeout.
               if (bus.case_done) begin
                  state_r       <= S_REC;
                  dut_reset_r   <= 1'b1;
                  case_active_r <= 1'b0;
               end else if (cycles_r == CYC_LIMIT) begin
                  state_r       <= S_DONE;
                  dut_reset_r   <= 1'b1;
                  case_active_r <= 1'b0;
                  timeout_r     <= 1'b1;
                  fail_mask_r   <= fail_mask_r | case_bit_s;
                  pass_r        <= 1'b0;
                  busy_r        <= 1'b0;
                  done_r        <= 1'b1;
               end else begin
                  cycles_r <= cycles_r + 1'b1;
               end
            end

            S_REC: begin
               fail_mask_r <= rec_mask_s;
               if (run_all_r && (case_id_r < LAST_ID)) begin
                  state_r   <= S_RST;
                  case_id_r <= case_id_r + 1'b1;
                  rst_cnt_r <= '0;
                  flag_r    <= 1'b0;
               end else begin
                  state_r <= S_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= sel_valid_r && !timeout_r && (rec_mask_s == {NUM_CASES{1'b0}});
               end
            end

            default: begin
               state_r       <= S_IDLE;
               dut_reset_r   <= 1'b1;
               case_active_r <= 1'b0;
               busy_r        <= 1'b0;
               done_r        <= 1'b0;
               pass_r        <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dut_reset   = dut_reset_r;
   assign bus.case_id     = case_id_r;
   assign bus.case_active = case_active_r;
   assign bus.cycles      = cycles_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.pass        = pass_r;
   assign bus.timeout     = timeout_r;
   assign bus.fail_mask   = fail_mask_r;

endmodule

// File: tb/tb_bist_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bist_sequencer
// Scoreboard bench for bist_sequencer (NUM_CASES=4, RESET_CYCLES=3, TIMEOUT=20).
// The stimulus process pushes expected case starts and run verdicts into
// queues; a monitor pops and compares them each time the DUT starts a case
// (case_active rises) or finishes a run (done rises).
// -----------------------------------------------------------------------------
module tb_bist_sequencer;
   localparam int NC = 4;
   localparam int RC = 3;
   localparam int TO = 20;
   localparam int CW = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   bist_sequencer_if #(.NUM_CASES(NC), .CW(CW)) bus ();

   bist_sequencer #(
      .NUM_CASES(NC), .RESET_CYCLES(RC), .TIMEOUT(TO), .CW(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct packed {
      logic [2:0] id;
      logic [7:0] gap;
   } run_t;

   typedef struct packed {
      logic [3:0]  mask;
      logic        pass;
      logic        to;
      logic [2:0]  id;
      logic [31:0] cyc;
   } done_t;

   run_t  exp_run[$];
   done_t exp_done[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_run(input int id, input int gap);
      run_t r;
      r.id  = 3'(id);
      r.gap = 8'(gap);
      exp_run.push_back(r);
   endtask

   task automatic push_done(input int mask, input int pass, input int to, input int id, input int cyc);
      done_t d;
      d.mask = 4'(mask);
      d.pass = 1'(pass);
      d.to   = 1'(to);
      d.id   = 3'(id);
      d.cyc  = 32'(cyc);
      exp_done.push_back(d);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int sel);
      bus.start    = 1'b1;
      bus.case_sel = 3'(sel);
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_active();
      int i = 0;
      while (bus.case_active !== 1'b1 && i < 50) begin
         tick();
         i++;
      end
      if (bus.case_active !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_active: case_active still %b after %0d cycles, expected 1", bus.case_active, i);
      end
   endtask

   task automatic wait_done();
      int i = 0;
      while (bus.done !== 1'b1 && i < 100) begin
         tick();
         i++;
      end
      if (bus.done !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_done: done still %b after %0d cycles, expected 1", bus.done, i);
      end
   endtask

   // Drive one case: k is the RUN cycle index (matches the expected cycles value).
   task automatic run_case(input int done_at, input int fail_at, input int start_at);
      wait_active();
      for (int k = 0; k < TO; k++) begin
         bus.case_done = (k == done_at);
         bus.case_fail = (k == fail_at);
         bus.start     = (k == start_at);
         if (k == start_at) bus.case_sel = 3'd2;
         tick();
         bus.case_done = 1'b0;
         bus.case_fail = 1'b0;
         bus.start     = 1'b0;
         if (k == done_at) break;
      end
   endtask

   task automatic check_reset_state(input string pfx);
      check({pfx, "_dut_reset"},   32'(bus.dut_reset),   32'd1);
      check({pfx, "_case_id"},     32'(bus.case_id),     32'd0);
      check({pfx, "_cycles"},      bus.cycles,           32'd0);
      check({pfx, "_fail_mask"},   32'(bus.fail_mask),   32'd0);
      check({pfx, "_timeout"},     32'(bus.timeout),     32'd0);
      check({pfx, "_pass"},        32'(bus.pass),        32'd0);
      check({pfx, "_busy"},        32'(bus.busy),        32'd0);
      check({pfx, "_done"},        32'(bus.done),        32'd0);
      check({pfx, "_case_active"}, 32'(bus.case_active), 32'd0);
   endtask

   // Monitor: compares case starts and run verdicts against the queues.
   initial begin
      run_t  r;
      done_t d;
      logic  prev_active;
      logic  prev_done;
      int    gap;
      prev_active = 1'b0;
      prev_done   = 1'b0;
      gap         = 0;
      forever begin
         @(negedge clk);
         if (bus.case_active === 1'b1 && !prev_active) begin
            if (exp_run.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL run_entry: unexpected start of case %0d", bus.case_id);
            end else begin
               r = exp_run.pop_front();
               check("run_case_id",      32'(bus.case_id),   32'(r.id));
               check("run_reset_gap",    32'(gap),           32'(r.gap));
               check("run_first_cycles", bus.cycles,         32'd0);
               check("run_dut_reset",    32'(bus.dut_reset), 32'd0);
            end
         end
         if (bus.done === 1'b1 && !prev_done) begin
            if (exp_done.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL done_entry: unexpected done, case_id %0d", bus.case_id);
            end else begin
               d = exp_done.pop_front();
               check("done_fail_mask", 32'(bus.fail_mask), 32'(d.mask));
               check("done_pass",      32'(bus.pass),      32'(d.pass));
               check("done_timeout",   32'(bus.timeout),   32'(d.to));
               check("done_case_id",   32'(bus.case_id),   32'(d.id));
               check("done_cycles",    bus.cycles,         d.cyc);
               check("done_dut_reset", 32'(bus.dut_reset), 32'd1);
               check("done_busy",      32'(bus.busy),      32'd0);
            end
         end
         // Count consecutive DUT-reset cycles of an active run before each case.
         if (bus.busy !== 1'b1) gap = 0;
         else if (bus.dut_reset === 1'b1 && bus.case_active !== 1'b1) gap++;
         else gap = 0;
         prev_active = (bus.case_active === 1'b1);
         prev_done   = (bus.done === 1'b1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Stimulus: directed scenarios with hand-computed expectations.
   initial begin
      bus.start     = 1'b0;
      bus.case_sel  = 3'd0;
      bus.case_done = 1'b0;
      bus.case_fail = 1'b0;
      reset         = 1'b0;
      tick();
      tick();
      check_reset_state("reset");
      reset = 1'b1;
      tick();

      // Run all, every case done at cycles==5, no failures.
      push_run(1, 3); push_run(2, 4); push_run(3, 4); push_run(4, 4);
      push_done(4'b0000, 1, 0, 4, 5);
      start_run(0);
      for (int c = 0; c < 4; c++) run_case(5, -1, -1);
      wait_done();
      tick();

      // Single case 3 with a failure pulse at cycle 2, done at cycle 4.
      push_run(3, 3);
      push_done(4'b0100, 0, 0, 3, 4);
      start_run(3);
      run_case(4, 2, -1);
      wait_done();
      tick();

      // Run all, case 2 never finishes: timeout at cycles==19, cases 3-4 skipped.
      push_run(1, 3); push_run(2, 4);
      push_done(4'b0010, 0, 1, 2, 19);
      start_run(0);
      run_case(5, -1, -1);
      run_case(-1, -1, -1);
      wait_done();
      tick();

      // Done+fail together in case 1; done exactly at the timeout cycle in case 2.
      push_run(1, 3); push_run(2, 4); push_run(3, 4); push_run(4, 4);
      push_done(4'b0001, 0, 0, 4, 5);
      start_run(0);
      run_case(3, 3, -1);
      run_case(19, -1, -1);
      run_case(5, -1, -1);
      run_case(5, -1, -1);
      wait_done();
      tick();

      // Restart from DONE with case 1; a start during RUN must be ignored.
      push_run(1, 3);
      push_done(4'b0000, 1, 0, 1, 5);
      start_run(1);
      run_case(5, -1, 2);
      wait_done();
      tick();

      // Reset asserted mid-RUN returns to the reset state on the next cycle.
      push_run(1, 3);
      start_run(0);
      wait_active();
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_reset_state("midrun");
      tick();

      // Out-of-range selection goes straight to DONE with pass=0.
      push_done(4'b0000, 0, 0, 0, 0);
      start_run(5);
      check("sel5_done_next", 32'(bus.done), 32'd1);
      check("sel5_busy",      32'(bus.busy), 32'd0);
      repeat (3) tick();

      check("run_queue_empty",  32'(exp_run.size()),  32'd0);
      check("done_queue_empty", 32'(exp_done.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
